// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshakes on both sides.
// Logic, arithmetic, compare and branch ops finish in one cycle. Shifts move
// one bit per cycle unless ALU_BARREL_SHIFT_EN is defined, in which case a
// single-cycle barrel shifter is built and the SHIFT state and counter are not.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             BrTaken
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_BNE = 4'b1001;
  localparam logic [3:0] OP_BLT = 4'b1010;
  localparam logic [3:0] OP_BGE = 4'b1011;
  localparam logic [3:0] OP_SLL = 4'b1100;
  localparam logic [3:0] OP_SRL = 4'b1101;
  localparam logic [3:0] OP_SLT = 4'b1110;
  localparam logic [3:0] OP_SRA = 4'b1111;

  localparam logic [1:0] S_IDLE  = 2'd0;
`ifndef ALU_BARREL_SHIFT_EN
  localparam logic [1:0] S_SHIFT = 2'd1;
`endif
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic             accept;
  logic [WIDTH:0]   eval;

`ifndef ALU_BARREL_SHIFT_EN
  logic [WIDTH-1:0]   sh_reg;
  logic [WIDTH-1:0]   sh_next;
  logic [SHAMT_W-1:0] cnt;
  logic [3:0]         sh_op;
`endif

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // Single-cycle evaluation; returns {branch_taken, result}. In the serial
  // build shifts return A unchanged, which is only used when shamt is zero.
  function automatic logic [WIDTH:0] eval_op(input logic [3:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] res;
    logic             cond;
    logic             br;
`ifdef ALU_BARREL_SHIFT_EN
    logic [SHAMT_W-1:0] sh;
    sh = b[SHAMT_W-1:0];
`endif
    res  = '0;
    cond = 1'b0;
    br   = 1'b0;
    case (op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_ADD: res = a + b;
      OP_SUB: res = a - b;
      OP_XOR: res = a ^ b;
      OP_BEQ: begin
        cond = (a == b);
        br   = cond;
        res  = {{(WIDTH-1){1'b0}}, cond};
      end
      OP_BNE: begin
        cond = (a != b);
        br   = cond;
        res  = {{(WIDTH-1){1'b0}}, cond};
      end
      OP_BLT: begin
        cond = ($signed(a) < $signed(b));
        br   = cond;
        res  = {{(WIDTH-1){1'b0}}, cond};
      end
      OP_BGE: begin
        cond = ($signed(a) >= $signed(b));
        br   = cond;
        res  = {{(WIDTH-1){1'b0}}, cond};
      end
      OP_SLT: begin
        cond = ($signed(a) < $signed(b));
        res  = {{(WIDTH-1){1'b0}}, cond};
      end
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL: res = a << sh;
      OP_SRL: res = a >> sh;
      OP_SRA: res = $signed(a) >>> sh;
`else
      OP_SLL: res = a;
      OP_SRL: res = a;
      OP_SRA: res = a;
`endif
      default: res = '0;
    endcase
    return {br, res};
  endfunction

  assign out_valid = (state == S_DONE);
  assign in_ready  = reset && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign eval      = eval_op(Operation, SrcA, SrcB);

`ifndef ALU_BARREL_SHIFT_EN
  // One-bit shift step of the iterative shifter; SRA replicates the MSB.
  always_comb begin
    sh_next = sh_reg;
    case (sh_op)
      OP_SLL:  sh_next = {sh_reg[WIDTH-2:0], 1'b0};
      OP_SRL:  sh_next = {1'b0, sh_reg[WIDTH-1:1]};
      default: sh_next = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
    endcase
  end
`endif

  // Control FSM plus result registers: accept, iterate shifts, hold result until taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ALUResult <= '0;
      BrTaken   <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      sh_reg    <= '0;
      cnt       <= '0;
      sh_op     <= '0;
`endif
    end else if (accept) begin
`ifndef ALU_BARREL_SHIFT_EN
      if (is_shift_op(Operation) && (SrcB[SHAMT_W-1:0] != '0)) begin
        sh_reg <= SrcA;
        cnt    <= SrcB[SHAMT_W-1:0];
        sh_op  <= Operation;
        state  <= S_SHIFT;
      end else
`endif
      begin
        ALUResult <= eval[WIDTH-1:0];
        BrTaken   <= eval[WIDTH];
        state     <= S_DONE;
      end
    end
`ifndef ALU_BARREL_SHIFT_EN
    else if (state == S_SHIFT) begin
      if (cnt == SHAMT_W'(1)) begin
        ALUResult <= sh_next;
        BrTaken   <= 1'b0;
        cnt       <= '0;
        state     <= S_DONE;
      end else begin
        sh_reg <= sh_next;
        cnt    <= cnt - SHAMT_W'(1);
      end
    end
`endif
    else if ((state == S_DONE) && out_ready) begin
      state <= S_IDLE;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against
// a transaction-level reference model (result and latency from the op rules).
// Build with ALU_BARREL_SHIFT_EN defined to check the barrel-shifter variant.
module tb_alu_exec_unit;

  localparam int W = 32;
`ifdef ALU_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   Operation = 4'h0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] ALUResult;
  logic         BrTaken;

  int total = 0;
  int bad = 0;

  bit           chk_en = 1'b0;
  bit           m_hold = 1'b0;
  bit           m_acc = 1'b0;
  longint       m_cyc = 0;
  longint       m_vc = 0;
  logic [W-1:0] m_res = '0;
  logic         m_br = 1'b0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .Operation(Operation),
    .SrcA(SrcA),
    .SrcB(SrcB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ALUResult(ALUResult),
    .BrTaken(BrTaken)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference result: {branch_taken, result} straight from the op table.
  function automatic logic [W:0] ref_op(input logic [3:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    int   sh;
    logic lt;
    logic eq;
    sh = int'(b[4:0]);
    lt = ($signed(a) < $signed(b));
    eq = (a == b);
    case (op)
      4'h0: return {1'b0, a & b};
      4'h1: return {1'b0, a | b};
      4'h2: return {1'b0, a + b};
      4'h3: return {1'b0, a - b};
      4'h4: return {1'b0, a ^ b};
      4'h8: return {eq, 31'b0, eq};
      4'h9: return {!eq, 31'b0, !eq};
      4'hA: return {lt, 31'b0, lt};
      4'hB: return {!lt, 31'b0, !lt};
      4'hE: return {1'b0, 31'b0, lt};
      4'hC: return {1'b0, a << sh};
      4'hD: return {1'b0, a >> sh};
      4'hF: return {1'b0, W'($signed(a) >>> sh)};
      default: return '0;
    endcase
  endfunction

  // Reference latency from accept to out_valid.
  function automatic int ref_lat(input logic [3:0] op, input logic [W-1:0] b);
    if (!BARREL && (op == 4'hC || op == 4'hD || op == 4'hF) && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
    return 1;
  endfunction

  task automatic check_value(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction model: one result slot, visible after its latency, freed on out_ready.
  always @(posedge clk) begin : model_upd
    logic       ov;
    logic       ir;
    logic [W:0] r;
    if (!reset) begin
      m_hold = 1'b0;
      m_acc  = 1'b0;
    end else begin
      ov    = m_hold && (m_cyc >= m_vc);
      ir    = !m_hold || (ov && out_ready);
      m_acc = in_valid && ir;
      if (ov && out_ready) m_hold = 1'b0;
      if (m_acc) begin
        r      = ref_op(Operation, SrcA, SrcB);
        m_res  = r[W-1:0];
        m_br   = r[W];
        m_hold = 1'b1;
        m_vc   = m_cyc + ref_lat(Operation, SrcB);
      end
    end
    m_cyc++;
  end

  // Every-cycle compare of the DUT handshake and outputs against the model.
  always @(negedge clk) begin : compare
    logic ov;
    logic ir;
    if (chk_en) begin
      if (!reset) begin
        check_value("rst_in_ready", in_ready, 0);
        check_value("rst_out_valid", out_valid, 0);
        check_value("rst_result", ALUResult, 0);
        check_value("rst_brtaken", BrTaken, 0);
      end else begin
        ov = m_hold && (m_cyc >= m_vc);
        ir = !m_hold || (ov && out_ready);
        check_value("in_ready", in_ready, ir);
        check_value("out_valid", out_valid, ov);
        if (ov) begin
          check_value("result", ALUResult, m_res);
          check_value("brtaken", BrTaken, m_br);
        end
      end
    end
  end

  task automatic wait_accept(input string name);
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (m_acc) break;
    end
    if (!m_acc) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_accept: got no accept expected accept within 200 cycles", name);
    end
  endtask

  // Issue one op with out_ready high, then pin latency, result and branch flag.
  task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_res,
                        input logic exp_br, input int exp_lat);
    int n;
    in_valid  = 1'b1;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    out_ready = 1'b1;
    wait_accept(name);
    in_valid  = 1'b0;
    Operation = 4'(($urandom));
    SrcA      = $urandom;
    SrcB      = $urandom;
    for (n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
    end
    check_value({name, "_lat"}, W'(n), W'(exp_lat));
    check_value({name, "_res"}, ALUResult, exp_res);
    check_value({name, "_br"}, BrTaken, exp_br);
    @(posedge clk);
    #1;
  endtask

  // Stimulus: reset, directed cases, backpressure, mid-shift reset, random traffic.
  initial begin
    int accepts;
    #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_op("add_ovf", 4'h2, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1);
    run_op("sub_wrap", 4'h3, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1);
    run_op("blt", 4'hA, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b1, 1);
    run_op("bge", 4'hB, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1);
    run_op("beq", 4'h8, 32'h1234, 32'h1234, 32'h1, 1'b1, 1);
    run_op("slt", 4'hE, 32'h5, 32'h3, 32'h0, 1'b0, 1);
    run_op("sra4", 4'hF, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0, BARREL ? 1 : 5);
    run_op("srl4", 4'hD, 32'h8000_0000, 32'h4, 32'h0800_0000, 1'b0, BARREL ? 1 : 5);
    run_op("sll31", 4'hC, 32'h1, 32'd31, 32'h8000_0000, 1'b0, BARREL ? 1 : 32);
    run_op("sll0", 4'hC, 32'hA5A5_0001, 32'h20, 32'hA5A5_0001, 1'b0, 1);
    run_op("undef6", 4'h6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);

    in_valid  = 1'b1;
    Operation = 4'h2;
    SrcA      = 32'd10;
    SrcB      = 32'd20;
    out_ready = 1'b0;
    wait_accept("bp_add");
    Operation = 4'h4;
    SrcA      = 32'd5;
    SrcB      = 32'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_value("bp_hold_valid", out_valid, 1);
      check_value("bp_hold_res", ALUResult, 32'd30);
      check_value("bp_hold_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_value("bp_release_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_value("bp_b2b_valid", out_valid, 1);
    check_value("bp_b2b_res", ALUResult, 32'h6);
    @(posedge clk);
    #1;

    in_valid  = 1'b1;
    Operation = 4'hC;
    SrcA      = 32'h1;
    SrcB      = 32'd20;
    out_ready = 1'b1;
    wait_accept("mid_sll");
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_value("mid_rst_valid", out_valid, 0);
    check_value("mid_rst_res", ALUResult, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_value("post_rst_ready", in_ready, 1);
    @(posedge clk);
    #1;
    run_op("xor_after_rst", 4'h4, 32'hFF, 32'h0F, 32'hF0, 1'b0, 1);

    accepts = 0;
    for (int t = 0; t < 9000 && accepts < 250; t++) begin
      if (!in_valid || m_acc) begin
        in_valid  = ($urandom_range(3) != 0);
        Operation = 4'($urandom_range(15));
        SrcA      = $urandom;
        SrcB      = ($urandom_range(3) == 0) ? SrcA : $urandom;
        if ($urandom_range(4) == 0) SrcB = W'($urandom_range(3));
      end
      out_ready = ($urandom_range(3) != 0);
      @(posedge clk);
      #1;
      if (m_acc) accepts++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
